// File: rtl/uart_frame_scheduler_pkg.sv
// uart_frame_pkg: shared state encoding, header defaults and frame index width for the UART frame scheduler
package uart_frame_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GUARD, ST_WAIT} state_e;
  localparam logic [7:0] PITCH_HDR_DEF = 8'hA5;
  localparam logic [7:0] SAMPLE_HDR_DEF = 8'h5A;
  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/uart_frame_scheduler_if.sv
// uart_frame_scheduler_if: report sources on one side, byte transmitter handshake on the other
interface uart_frame_scheduler_if;
  import uart_frame_pkg::*;
  logic [10:0] pitch_in;
  logic pitch_valid_in;
  logic [15:0] sample_in;
  logic sample_valid_in;
  logic [1:0] enable_in;
  logic tx_busy_in;
  logic [7:0] tx_byte_out;
  logic tx_trigger_out;
  logic frame_active_out;
  logic [7:0] drop_count_out;
  modport master (
    output pitch_in, pitch_valid_in, sample_in, sample_valid_in, enable_in, tx_busy_in,
    input tx_byte_out, tx_trigger_out, frame_active_out, drop_count_out
  );
  modport slave (
    input pitch_in, pitch_valid_in, sample_in, sample_valid_in, enable_in, tx_busy_in,
    output tx_byte_out, tx_trigger_out, frame_active_out, drop_count_out
  );
endinterface

// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: arbitrates pitch and decimated sample reports into 4-byte frames paced by transmitter busy
module uart_frame_scheduler
  import uart_frame_pkg::*;
#(
  parameter int SAMPLE_DECIM = 4800,
  parameter logic [7:0] PITCH_HDR = PITCH_HDR_DEF,
  parameter logic [7:0] SAMPLE_HDR = SAMPLE_HDR_DEF
) (
  input logic clk_in,
  input logic rst_in,
  uart_frame_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] GUARD = ST_GUARD;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam int DW = $clog2(SAMPLE_DECIM) + 1;
  logic [1:0] state;
  idx_t idx, nxt;
  logic [3:0][7:0] frame;
  logic [7:0] tx_byte, drop_cnt, hdr, hi, lo;
  logic [8:0] drop_sum;
  logic p_pend, s_pend, p_acc, s_hit, s_acc, load, p_clr, s_clr, p_drop, s_drop;
  logic [10:0] p_val;
  logic [15:0] s_val;
  logic [DW-1:0] dcnt;
  assign p_acc = bus.pitch_valid_in & bus.enable_in[0];
  assign s_hit = bus.sample_valid_in & bus.enable_in[1];
  assign s_acc = s_hit & (dcnt == '0);
  assign load = (state == IDLE) & (p_pend | s_pend) & ~bus.tx_busy_in;
  assign p_clr = load & p_pend;
  assign s_clr = load & ~p_pend;
  assign p_drop = p_acc & p_pend & ~p_clr;
  assign s_drop = s_acc & s_pend & ~s_clr;
  assign drop_sum = {1'b0, drop_cnt} + 9'(p_drop) + 9'(s_drop);
  assign hdr = p_pend ? PITCH_HDR : SAMPLE_HDR;
  assign hi = p_pend ? {5'b0, p_val[10:8]} : s_val[15:8];
  assign lo = p_pend ? p_val[7:0] : s_val[7:0];
  assign nxt = idx + 1'b1;
  assign bus.tx_byte_out = tx_byte;
  assign bus.tx_trigger_out = state == SEND;
  assign bus.frame_active_out = state != IDLE;
  assign bus.drop_count_out = drop_cnt;
  // Pending registers, sample decimator and saturating overwrite counter
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      p_pend <= 1'b0;
      s_pend <= 1'b0;
      p_val <= '0;
      s_val <= '0;
      dcnt <= '0;
      drop_cnt <= '0;
    end else begin
      p_pend <= bus.enable_in[0] & (p_acc | (p_pend & ~p_clr));
      s_pend <= bus.enable_in[1] & (s_acc | (s_pend & ~s_clr));
      if (p_acc) p_val <= bus.pitch_in;
      if (s_acc) s_val <= bus.sample_in;
      dcnt <= ~bus.enable_in[1] ? '0 : ~s_hit ? dcnt : (dcnt == DW'(SAMPLE_DECIM - 1)) ? '0 : dcnt + 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
  // Frame sequencer: load, then trigger each byte and wait out the transmitter
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
      idx <= '0;
      frame <= '0;
      tx_byte <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          frame <= {hdr ^ hi ^ lo, lo, hi, hdr};
          tx_byte <= hdr;
          idx <= '0;
          state <= SEND;
        end
        SEND: state <= GUARD;
        GUARD: state <= WAIT;
        default: if (!bus.tx_busy_in) begin
          if (idx == idx_t'(3)) state <= IDLE;
          else begin
            idx <= nxt;
            tx_byte <= frame[nxt];
            state <= SEND;
          end
        end
      endcase
    end
  end
endmodule
